guest_joy_mapper: RTL and testbench

GUEST_JOY_MAPPER -- requirements
Module: guest_joy_mapper

---
 rtl/guest_joy_mapper.sv | 209 ++++++++++++++++++++
 tb/tb_guest_joy_mapper.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/guest_joy_mapper.sv
// Joystick conditioning for guest cores: optional ch0/ch1 swap, opposing-direction
// (SOCD) cleanup and per-channel autofire on fire1, all behind one register stage.
module guest_joy_mapper #(
    parameter int NUM_JOY     = 2,
    parameter int AF_PRESCALE = 28000
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic [NUM_JOY*8-1:0]   joy_in,
    input  logic [1:0]             socd_mode,
    input  logic [NUM_JOY*2-1:0]   af_rate,
    input  logic                   swap,
    output logic [NUM_JOY*6-1:0]   joy_out
);

    typedef enum logic [1:0] {
        AF_IDLE = 2'd0,
        AF_ON   = 2'd1,
        AF_OFF  = 2'd2
    } af_state_t;

    localparam int SW1 = (NUM_JOY >= 2) ? 1 : 0;
    localparam logic [31:0] PRESC_MAX = 32'(AF_PRESCALE - 1);

    logic [31:0]                presc_q, presc_d;
    logic                       tick;
    logic                       swap_q, swap_d;
    logic                       swap_chg;
    logic [NUM_JOY-1:0][3:0]    prev_q, prev_d;
    logic [NUM_JOY-1:0][1:0]    mem_q, mem_d;
    af_state_t                  af_q [NUM_JOY];
    af_state_t                  af_d [NUM_JOY];
    logic [NUM_JOY-1:0][7:0]    afc_q, afc_d;
    logic [NUM_JOY*6-1:0]       joy_out_q, joy_out_d;
    logic [NUM_JOY-1:0]         unused_bit7;

    // Resolve one axis under last-wins: returns {out_a, out_b, new_memory}.
    // Memory 0 selects a (up/left), 1 selects b (down/right); a rising edge on a wins ties.
    function automatic logic [2:0] last_wins(input logic a, input logic b,
                                             input logic pa, input logic pb,
                                             input logic m);
        logic nm;
        logic [1:0] o;
        if (a && !b) begin
            nm = 1'b0;
        end else if (b && !a) begin
            nm = 1'b1;
        end else if (a && b) begin
            if (!pa) begin
                nm = 1'b0;
            end else if (!pb) begin
                nm = 1'b1;
            end else begin
                nm = m;
            end
        end else begin
            nm = m;
        end
        if (a && b) begin
            o = {~nm, nm};
        end else begin
            o = {a, b};
        end
        return {o, nm};
    endfunction

    // Shared autofire prescaler and swap-change detection.
    always_comb begin
        tick     = 1'b0;
        presc_d  = presc_q + 32'd1;
        if (presc_q >= PRESC_MAX) begin
            presc_d = 32'd0;
            tick    = 1'b1;
        end else begin
            tick    = 1'b0;
        end
        swap_d   = swap;
        swap_chg = (swap != swap_q) && (NUM_JOY >= 2);
    end

    // Per-channel swap, SOCD resolution and autofire next-state.
    always_comb begin
        prev_d      = '0;
        mem_d       = '0;
        afc_d       = '0;
        joy_out_d   = '0;
        unused_bit7 = '0;
        for (int ch = 0; ch < NUM_JOY; ch++) begin
            int         src;
            logic       clr;
            logic [7:0] cur;
            logic [3:0] pv;
            logic [1:0] mv;
            logic [2:0] rv;
            logic [2:0] rh;
            logic [3:0] dir;
            logic [1:0] rate;
            logic [7:0] half_m1;
            logic       en;
            logic       fire1;

            af_d[ch] = AF_IDLE;
            if (swap && (NUM_JOY >= 2) && ch == 0) begin
                src = SW1;
            end else if (swap && (NUM_JOY >= 2) && ch == SW1) begin
                src = 0;
            end else begin
                src = ch;
            end
            cur             = joy_in[src*8 +: 8];
            unused_bit7[ch] = cur[7];
            clr             = swap_chg && (ch < 2);

            if (clr) begin
                pv = 4'b0000;
                mv = 2'b00;
            end else begin
                pv = prev_q[ch];
                mv = mem_q[ch];
            end
            rv          = last_wins(cur[0], cur[1], pv[0], pv[1], mv[0]);
            rh          = last_wins(cur[2], cur[3], pv[2], pv[3], mv[1]);
            prev_d[ch]  = cur[3:0];
            mem_d[ch]   = {rh[0], rv[0]};

            case (socd_mode)
                2'b01: begin
                    dir[1:0] = (cur[0] && cur[1]) ? 2'b00 : cur[1:0];
                    dir[3:2] = (cur[2] && cur[3]) ? 2'b00 : cur[3:2];
                end
                2'b10: begin
                    dir = {rh[1], rh[2], rv[1], rv[2]};
                end
                default: begin
                    dir = cur[3:0];
                end
            endcase

            rate = af_rate[ch*2 +: 2];
            case (rate)
                2'b00:   half_m1 = 8'd24;
                2'b01:   half_m1 = 8'd49;
                2'b10:   half_m1 = 8'd99;
                default: half_m1 = 8'd255;
            endcase
            en = cur[6] && (rate != 2'b11);

            if (!en || clr) begin
                af_d[ch]  = AF_IDLE;
                afc_d[ch] = 8'd0;
            end else begin
                case (af_q[ch])
                    AF_IDLE: begin
                        af_d[ch]  = AF_ON;
                        afc_d[ch] = 8'd0;
                    end
                    AF_ON, AF_OFF: begin
                        // >= so a shorter rate chosen mid-phase still terminates the phase
                        if (tick && (afc_q[ch] >= half_m1)) begin
                            af_d[ch]  = (af_q[ch] == AF_ON) ? AF_OFF : AF_ON;
                            afc_d[ch] = 8'd0;
                        end else if (tick) begin
                            af_d[ch]  = af_q[ch];
                            afc_d[ch] = afc_q[ch] + 8'd1;
                        end else begin
                            af_d[ch]  = af_q[ch];
                            afc_d[ch] = afc_q[ch];
                        end
                    end
                    default: begin
                        af_d[ch]  = AF_IDLE;
                        afc_d[ch] = 8'd0;
                    end
                endcase
            end

            fire1                 = cur[4] || (af_d[ch] == AF_ON);
            joy_out_d[ch*6 +: 6]  = {cur[5], fire1, dir};
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            presc_q   <= 32'd0;
            swap_q    <= 1'b0;
            prev_q    <= '0;
            mem_q     <= '0;
            afc_q     <= '0;
            joy_out_q <= '0;
            for (int ch = 0; ch < NUM_JOY; ch++) begin
                af_q[ch] <= AF_IDLE;
            end
        end else begin
            presc_q   <= presc_d;
            swap_q    <= swap_d;
            prev_q    <= prev_d;
            mem_q     <= mem_d;
            afc_q     <= afc_d;
            joy_out_q <= joy_out_d;
            for (int ch = 0; ch < NUM_JOY; ch++) begin
                af_q[ch] <= af_d[ch];
            end
        end
    end

    assign joy_out = joy_out_q;

endmodule

// File: tb/tb_guest_joy_mapper.sv
// Directed self-checking bench for guest_joy_mapper (two channels, fast prescaler).
module tb_guest_joy_mapper;

    logic        clk_sys;
    logic        reset_n;
    logic [15:0] joy_in;
    logic [1:0]  socd_mode;
    logic [3:0]  af_rate;
    logic        swap;
    logic [11:0] joy_out;

    int checks;
    int failures;

    guest_joy_mapper #(.NUM_JOY(2), .AF_PRESCALE(4)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .joy_in    (joy_in),
        .socd_mode (socd_mode),
        .af_rate   (af_rate),
        .swap      (swap),
        .joy_out   (joy_out)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Counts consecutive samples with fire1 of ch0 at lvl (bounded).
    task automatic measure(input logic lvl, output int n);
        n = 0;
        while (joy_out[4] === lvl && n < 300) begin
            n++;
            step();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        joy_in    = 16'hFFFF;
        socd_mode = 2'b00;
        af_rate   = 4'b0000;
        swap      = 1'b0;
        reset_n   = 1'b0;
        step();
        step();
        checks++;
        if (joy_out !== 12'h000) begin
            failures++;
            $display("FAIL reset_out got=%h exp=%h", joy_out, 12'h000);
        end
        joy_in  = 16'h0000;
        reset_n = 1'b1;
        step();
        checks++;
        if (joy_out !== 12'h000) begin
            failures++;
            $display("FAIL reset_idle got=%h exp=%h", joy_out, 12'h000);
        end
    endtask

    task automatic test_pass();
        socd_mode = 2'b00;
        joy_in    = 16'h0005;
        step();
        checks++;
        if (joy_out !== {6'b000000, 6'b000101}) begin
            failures++;
            $display("FAIL pass_05 got=%b exp=%b", joy_out, {6'b000000, 6'b000101});
        end
        joy_in = 16'h0F03;
        step();
        checks++;
        if (joy_out !== {6'b001111, 6'b000011}) begin
            failures++;
            $display("FAIL pass_opposed got=%b exp=%b", joy_out, {6'b001111, 6'b000011});
        end
        socd_mode = 2'b11;
        step();
        checks++;
        if (joy_out !== {6'b001111, 6'b000011}) begin
            failures++;
            $display("FAIL pass_mode11 got=%b exp=%b", joy_out, {6'b001111, 6'b000011});
        end
    endtask

    task automatic test_neutral();
        socd_mode = 2'b01;
        joy_in    = 16'h0003;
        step();
        checks++;
        if (joy_out[5:0] !== 6'b000000) begin
            failures++;
            $display("FAIL neutral_03 got=%b exp=%b", joy_out[5:0], 6'b000000);
        end
        joy_in = 16'h000F;
        step();
        checks++;
        if (joy_out[5:0] !== 6'b000000) begin
            failures++;
            $display("FAIL neutral_0F got=%b exp=%b", joy_out[5:0], 6'b000000);
        end
        joy_in = 16'h0007;
        step();
        checks++;
        if (joy_out[5:0] !== 6'b000100) begin
            failures++;
            $display("FAIL neutral_07 got=%b exp=%b", joy_out[5:0], 6'b000100);
        end
    endtask

    task automatic test_last_wins();
        logic [7:0]  vec [8];
        logic [5:0]  exp [8];
        vec = '{8'h00, 8'h01, 8'h03, 8'h01, 8'h00, 8'h03, 8'h04, 8'h0C};
        exp = '{6'b000000, 6'b000001, 6'b000010, 6'b000001,
                6'b000000, 6'b000001, 6'b000100, 6'b001000};
        socd_mode = 2'b10;
        for (int i = 0; i < 8; i++) begin
            joy_in = {8'h00, vec[i]};
            step();
            checks++;
            if (joy_out[5:0] !== exp[i]) begin
                failures++;
                $display("FAIL last_wins[%0d] in=%h got=%b exp=%b", i, vec[i], joy_out[5:0], exp[i]);
            end
        end
        joy_in = 16'h0000;
        step();
    endtask

    task automatic test_autofire();
        int n;
        int lows;
        socd_mode = 2'b00;
        af_rate   = 4'b0000;
        joy_in    = 16'h0040;
        step();
        checks++;
        if (joy_out[4] !== 1'b1) begin
            failures++;
            $display("FAIL af_first_on got=%b exp=1", joy_out[4]);
        end
        measure(1'b1, n);
        checks++;
        if (n < 97 || n > 100) begin
            failures++;
            $display("FAIL af_first_on_len got=%0d exp=97..100", n);
        end
        measure(1'b0, n);
        checks++;
        if (n != 100) begin
            failures++;
            $display("FAIL af_off_len got=%0d exp=100", n);
        end
        measure(1'b1, n);
        checks++;
        if (n != 100) begin
            failures++;
            $display("FAIL af_on_len got=%0d exp=100", n);
        end
        checks++;
        if (joy_out[11:6] !== 6'b000000 || joy_out[3:0] !== 4'b0000 || joy_out[5] !== 1'b0) begin
            failures++;
            $display("FAIL af_isolation got=%b exp=%b", joy_out, {6'b000000, 6'b000000});
        end
        joy_in = 16'h0050;
        lows   = 0;
        for (int i = 0; i < 250; i++) begin
            step();
            if (joy_out[4] !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL af_manual_override low_samples=%0d exp=0", lows);
        end
        joy_in = 16'h0000;
        step();
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (joy_out[4] !== 1'b0) lows++;
            step();
        end
        checks++;
        if (lows != 0) begin
            failures++;
            $display("FAIL af_release high_samples=%0d exp=0", lows);
        end
        af_rate = 4'b0011;
        joy_in  = 16'h0060;
        step();
        checks++;
        if (joy_out[5:0] !== 6'b100000) begin
            failures++;
            $display("FAIL af_disabled got=%b exp=%b", joy_out[5:0], 6'b100000);
        end
        af_rate = 4'b0000;
        joy_in  = 16'h0000;
        step();
    endtask

    task automatic test_swap();
        do_reset();
        swap   = 1'b0;
        joy_in = {8'h10, 8'h01};
        step();
        checks++;
        if (joy_out !== {6'b010000, 6'b000001}) begin
            failures++;
            $display("FAIL swap_off got=%b exp=%b", joy_out, {6'b010000, 6'b000001});
        end
        swap = 1'b1;
        step();
        checks++;
        if (joy_out !== {6'b000001, 6'b010000}) begin
            failures++;
            $display("FAIL swap_on got=%b exp=%b", joy_out, {6'b000001, 6'b010000});
        end
        swap   = 1'b0;
        joy_in = 16'h4040;
        step();
        step();
        checks++;
        if (joy_out !== {6'b010000, 6'b010000}) begin
            failures++;
            $display("FAIL swap_af_running got=%b exp=%b", joy_out, {6'b010000, 6'b010000});
        end
        swap = 1'b1;
        step();
        checks++;
        if (joy_out !== 12'h000) begin
            failures++;
            $display("FAIL swap_af_cleared got=%b exp=%b", joy_out, 12'h000);
        end
        step();
        checks++;
        if (joy_out !== {6'b010000, 6'b010000}) begin
            failures++;
            $display("FAIL swap_af_restart got=%b exp=%b", joy_out, {6'b010000, 6'b010000});
        end
        swap   = 1'b0;
        joy_in = 16'h0000;
        step();
    endtask

    task automatic test_reset_midburst();
        int n;
        do_reset();
        af_rate = 4'b0000;
        joy_in  = 16'h0040;
        for (int i = 0; i < 11; i++) step();
        checks++;
        if (joy_out[4] !== 1'b1) begin
            failures++;
            $display("FAIL midburst_pre got=%b exp=1", joy_out[4]);
        end
        reset_n = 1'b0;
        step();
        checks++;
        if (joy_out !== 12'h000) begin
            failures++;
            $display("FAIL midburst_reset got=%h exp=%h", joy_out, 12'h000);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (joy_out[4] !== 1'b1) begin
            failures++;
            $display("FAIL midburst_restart got=%b exp=1", joy_out[4]);
        end
        measure(1'b1, n);
        checks++;
        if (n < 97 || n > 100) begin
            failures++;
            $display("FAIL midburst_on_len got=%0d exp=97..100", n);
        end
        joy_in = 16'h0000;
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vec [4];
        logic [11:0] exp [4];
        vec = '{16'h0A05, 16'h050A, 16'h2030, 16'h0000};
        exp = '{{6'b001010, 6'b000101}, {6'b000101, 6'b001010},
                {6'b100000, 6'b110000}, {6'b000000, 6'b000000}};
        socd_mode = 2'b00;
        for (int i = 0; i < 4; i++) begin
            joy_in = vec[i];
            step();
            checks++;
            if (joy_out !== exp[i]) begin
                failures++;
                $display("FAIL b2b[%0d] got=%b exp=%b", i, joy_out, exp[i]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_pass();
        test_neutral();
        test_last_wins();
        test_autofire();
        test_swap();
        test_reset_midburst();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
